// File: rtl/ma_pipe_adder_if.sv
// Operand/result handshake bundle for ma_pipe_adder.
// The master side supplies operands and consumes results; the slave side is the adder.
interface ma_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/ma_pipe_adder.sv
// Pipelined ripple-carry adder/subtractor built from CHUNK-bit slices.
// Pipeline level k holds the sum bits of slices 0..k, the carry into slice k+1,
// the untouched operand bits of the upper slices and a valid bit. The last level
// is the registered output, so an op accepted at edge n is presented after
// edge n+STAGES-1. The whole pipeline advances together whenever the output is
// empty or being consumed; otherwise every register holds.
module ma_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    ma_pipe_adder_if.slave   bus
);
    localparam int STAGES = WIDTH / CHUNK;

    // Pipeline registers, one entry per level
    logic [WIDTH-1:0] pa [STAGES];
    logic [WIDTH-1:0] pb [STAGES];
    logic [WIDTH-1:0] ps [STAGES];
    logic             pc [STAGES];
    logic             pv [STAGES];
    logic             ovf_q;

    // Values feeding each level's slice adder
    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic             src_v [STAGES];
    logic [CHUNK:0]   slice_sum [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic             nxt_ovf;
    logic             en;

    // Global advance: the output slot is free or is being taken this cycle
    always_comb begin
        en = ~pv[STAGES-1] | bus.out_ready;
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = pv[STAGES-1];
    assign bus.s         = ps[STAGES-1];
    assign bus.cout      = pc[STAGES-1];
    assign bus.ovf       = ovf_q;

    // Slice adders: level 0 works on the live operands, later levels on the previous level
    always_comb begin
        src_a[0] = bus.a;
        src_b[0] = bus.sub ? ~bus.b : bus.b;
        src_s[0] = '0;
        src_c[0] = bus.sub ? 1'b1 : bus.cin;
        src_v[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = pa[k-1];
            src_b[k] = pb[k-1];
            src_s[k] = ps[k-1];
            src_c[k] = pc[k-1];
            src_v[k] = pv[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                         + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, src_c[k]};
            nxt_s[k] = src_s[k];
            nxt_s[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
        end
        // Carry into the MSB is recovered from the MSB sum bit; overflow is that XOR carry out
        nxt_ovf = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
                ^ slice_sum[STAGES-1][CHUNK-1] ^ slice_sum[STAGES-1][CHUNK];
    end

    // Pipeline advance with synchronous reset; the output level only loads real results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                pa[k] <= '0;
                pb[k] <= '0;
                ps[k] <= '0;
                pc[k] <= 1'b0;
                pv[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                pv[k] <= src_v[k];
                if (k != STAGES-1 || src_v[k]) begin
                    pa[k] <= src_a[k];
                    pb[k] <= src_b[k];
                    ps[k] <= nxt_s[k];
                    pc[k] <= slice_sum[k][CHUNK];
                end
            end
            if (src_v[STAGES-1]) begin
                ovf_q <= nxt_ovf;
            end
        end
    end
endmodule

// File: tb/tb_ma_pipe_adder.sv
// Self-checking bench for ma_pipe_adder: a 16/4 instance carries most checks,
// an 8/8 (single stage) and a 12/1 (twelve stages) instance repeat the basics.
module tb_ma_pipe_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ma_pipe_adder_if #(.WIDTH(16)) bw ();
    ma_pipe_adder_if #(.WIDTH(8))  bn ();
    ma_pipe_adder_if #(.WIDTH(12)) bs ();

    ma_pipe_adder #(.WIDTH(16), .CHUNK(4)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bw.slave));
    ma_pipe_adder #(.WIDTH(8),  .CHUNK(8)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bn.slave));
    ma_pipe_adder #(.WIDTH(12), .CHUNK(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs.slave));

    // Watchdog so a stuck pipeline still ends the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic driveOp(input int which, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub, input logic v);
        case (which)
            0: begin bw.in_valid = v; bw.a = a;        bw.b = b;        bw.cin = cin; bw.sub = sub; end
            1: begin bn.in_valid = v; bn.a = a[7:0];   bn.b = b[7:0];   bn.cin = cin; bn.sub = sub; end
            default: begin bs.in_valid = v; bs.a = a[11:0]; bs.b = b[11:0]; bs.cin = cin; bs.sub = sub; end
        endcase
    endtask

    function automatic logic [31:0] resultOf(input int which);
        case (which)
            0:       return {14'h0, bw.cout, bw.ovf, bw.s};
            1:       return {14'h0, bn.cout, bn.ovf, 8'h00, bn.s};
            default: return {14'h0, bs.cout, bs.ovf, 4'h0, bs.s};
        endcase
    endfunction

    function automatic logic [31:0] validOf(input int which);
        case (which)
            0:       return {31'h0, bw.out_valid};
            1:       return {31'h0, bn.out_valid};
            default: return {31'h0, bs.out_valid};
        endcase
    endfunction

    // Reference arithmetic via the signed-overflow sign rule
    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bx;
        logic [16:0] t;
        logic        o;
        bx = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, bx} + {16'h0, (sub ? 1'b1 : cin)};
        o  = (a[15] == bx[15]) && (t[15] != a[15]);
        return {14'h0, t[16], o, t[15:0]};
    endfunction

    // One isolated operation: output must stay invalid until exactly STAGES-1 edges after accept
    task automatic applyStimulus(input int which, input string tag, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin, input logic sub,
                                 input logic [15:0] es, input logic ec, input logic eo);
        int nst;
        nst = (which == 0) ? 4 : ((which == 1) ? 1 : 12);
        @(negedge clk);
        driveOp(which, a, b, cin, sub, 1'b1);
        @(posedge clk);
        @(negedge clk);
        driveOp(which, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nst - 1; i++) begin
            checkOutput({tag, "_early"}, validOf(which), 32'd0);
            @(negedge clk);
        end
        checkOutput({tag, "_vld"}, validOf(which), 32'd1);
        checkOutput({tag, "_res"}, resultOf(which), {14'h0, ec, eo, es});
        @(negedge clk);
    endtask

    // Random stream on the 16-bit instance with an in-order scoreboard
    task automatic runStream(input int nops, input int pvalid, input int pready, input string tag);
        logic [31:0] q[$];
        logic [31:0] held;
        logic        was_stall;
        logic        v, r, cin, sub;
        logic [15:0] a, b;
        int          sent;
        int          cycles;
        sent = 0;
        cycles = 0;
        was_stall = 1'b0;
        held = '0;
        while ((sent < nops || q.size() > 0) && cycles < 20 * nops + 100) begin
            @(negedge clk);
            if (was_stall) begin
                checkOutput({tag, "_holdv"}, validOf(0), 32'd1);
                checkOutput({tag, "_hold"}, resultOf(0), held);
            end
            v   = (sent < nops) && ($urandom_range(99) < pvalid);
            r   = ($urandom_range(99) < pready);
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom_range(1));
            sub = ($urandom_range(3) == 0);
            driveOp(0, a, b, cin, sub, v);
            bw.out_ready = r;
            #1;
            checkOutput({tag, "_rdy"}, {31'h0, bw.in_ready}, {31'h0, (~bw.out_valid | r)});
            if (bw.out_valid && r) begin
                if (q.size() == 0) checkOutput({tag, "_dup"}, 32'(q.size()), 32'd1);
                else checkOutput({tag, "_res"}, resultOf(0), q.pop_front());
            end
            if (v && bw.in_ready) begin
                q.push_back(model(a, b, cin, sub));
                sent++;
            end
            was_stall = bw.out_valid && !r;
            held = resultOf(0);
            cycles++;
        end
        checkOutput({tag, "_left"}, 32'(q.size()), 32'd0);
        checkOutput({tag, "_sent"}, 32'(sent), 32'(nops));
        @(negedge clk);
        driveOp(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        bw.out_ready = 1'b1;
    endtask

    initial begin
        for (int w = 0; w < 3; w++) driveOp(w, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        bw.out_ready = 1'b1;
        bn.out_ready = 1'b1;
        bs.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_vld", validOf(0), 32'd0);
        checkOutput("rst_res", resultOf(0), 32'd0);
        checkOutput("rst_vld_n", validOf(1), 32'd0);
        checkOutput("rst_vld_s", validOf(2), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_rdy", {31'h0, bw.in_ready}, 32'd1);

        applyStimulus(0, "add",      16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        applyStimulus(0, "ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(0, "sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        applyStimulus(0, "sub_neg",  16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        applyStimulus(0, "add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus(0, "cin",      16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
        applyStimulus(0, "sub_cin",  16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        applyStimulus(0, "neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        applyStimulus(0, "all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        applyStimulus(1, "n_add",    16'h0034, 16'h0011, 1'b0, 1'b0, 16'h0045, 1'b0, 1'b0);
        applyStimulus(1, "n_ripple", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(2, "s_add",    16'h0234, 16'h0111, 1'b0, 1'b0, 16'h0345, 1'b0, 1'b0);
        applyStimulus(2, "s_ripple", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(2, "s_subovf", 16'h0800, 16'h0001, 1'b0, 1'b1, 16'h07FF, 1'b1, 1'b1);

        runStream(100, 100, 100, "b2b");
        runStream(150, 60, 50, "stall");

        // Three ops in flight, then a one-cycle reset
        @(negedge clk); driveOp(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        @(negedge clk); driveOp(0, 16'h3333, 16'h4444, 1'b1, 1'b0, 1'b1);
        @(negedge clk); driveOp(0, 16'h5555, 16'h0001, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        driveOp(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid_rst_vld", validOf(0), 32'd0);
        checkOutput("mid_rst_res", resultOf(0), 32'd0);
        checkOutput("mid_rst_rdy", {31'h0, bw.in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("no_stale", validOf(0), 32'd0);
        end
        applyStimulus(0, "post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
